dsram_responder: RTL and testbench
==================================

# dsram_responder

Responder end of the CPU data-SRAM interface: accepts the `data_sram_*` requests issued by the MEM stage and returns synchronous read data one cycle later, exactly as a block-RAM port would. Besides a local word-addressed RAM it decodes a small configuration-register window (LED, switch, free-running timer with compare/interrupt). It sits in the SoC top between the CPU's data port and the board I/O, replacing a bare data RAM instance.

## Interface
- `RAM_AW`, 10, RAM word-address width; depth = 2^RAM_AW words.
- `CONF_HI`, 16'hbfaf, value of `data_sram_addr[31:16]` selecting the config window.
- `clk`  in  1  single clock, all state on rising edge.
- `resetn`  in  1  one clock; reset is asynchronous and active-low.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_wen`  in  4  byte write enables; 0 = read, non-zero = write.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data, byte lane i = bits [8i+7:8i].
- `data_sram_rdata`  out  32  read data, valid the cycle after a read request.
- `switch`  in  8  asynchronous board switches.
- `led`  out  16  LED register.
- `timer_irq`  out  1  sticky timer-match flag.

## Operation
- Decode: `conf_sel = (addr[31:16] == CONF_HI)`; otherwise RAM at word index `addr[RAM_AW+1:2]` (upper bits aliased).
- Config offsets (`addr[15:0]`):
  - 0xf000 LED: rw, bits [15:0]; [31:16] read 0.
  - 0xf004 SWITCH: ro, zero-extended 2-flop-synchronised `switch`.
  - 0xf008 TIMER: rw, increments by 1 every cycle, wraps 0xffffffff -> 0.
  - 0xf00c COMPARE: rw.
  - 0xf010 STATUS: bit0 = match flag; write 1 to bit0 clears; other bits read 0.
  - any other offset: reads 0, writes ignored.
- Writes (`en && wen != 0`): each rw register / RAM word updates only the bytes whose `wen` bit is set. Writes to SWITCH ignored.
- Reads (`en && wen == 0`): selected word registered into `data_sram_rdata`.
- `data_sram_rdata` holds its value on idle cycles and on write cycles.
- Match: when TIMER value (pre-increment) equals COMPARE, match flag sets on next edge. `timer_irq` = match flag.
- RAM contents are not reset; all registers are.

## Timing
- Reset (async, `resetn`=0): `data_sram_rdata`=0, `led`=0, TIMER=0, COMPARE=0xffffffff, match flag=0 (`timer_irq`=0), switch synchroniser=0. Takes effect immediately, mid-transaction included; a read issued in the cycle reset asserts returns nothing (rdata stays 0).
- Read latency exactly 1 cycle: request at edge N sampled, data visible after edge N, stable until next read completes. Back-to-back reads every cycle supported.
- Read-after-write, same address, consecutive cycles: second read returns newly written data.
- SWITCH read reflects pin value from at least 2 cycles earlier.
- TIMER write in cycle N: TIMER = written bytes (merged) after edge N; no increment that cycle; value+1 after edge N+1. A TIMER read returns the value before that edge's update.
- Match-set and write-1-clear in same cycle: set wins, flag stays 1.
- COMPARE write and equality in same cycle: compare uses old COMPARE.

## Test plan
- Reset then read RAM word 0x100 after writing 0xdeadbeef with wen=4'hf -> rdata=0xdeadbeef one cycle after read request, holds during 3 idle cycles.
- Write 0x11223344 (wen=f), then wen=4'b0101 with 0xaabbccdd, read -> 0x11bb33dd; back-to-back reads of two addresses return in consecutive cycles.
- Write LED 0x1234abcd -> `led`=0xabcd, read LED -> 0x0000abcd; write SWITCH ignored; `switch`=0x5a -> SWITCH read 0x5a after ≥2 cycles; read offset 0xf020 -> 0.
- Write TIMER=0xfffffffe, COMPARE=0xffffffff -> `timer_irq` rises 2 cycles later, TIMER wraps to 0; write STATUS bit0=1 -> `timer_irq`=0; clear coinciding with match -> stays 1.
- Assert `resetn`=0 mid-stream (read pending, LED=0xffff, irq=1) -> all outputs 0 immediately, TIMER restarts from 0 on release.

Source files
------------

// File: rtl/dsram_responder.sv
// rtl/dsram_responder.sv - data-SRAM responder with local RAM and config register window
module dsram_responder #(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] CONF_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam logic [15:0] OFF_LED     = 16'hf000;
  localparam logic [15:0] OFF_SWITCH  = 16'hf004;
  localparam logic [15:0] OFF_TIMER   = 16'hf008;
  localparam logic [15:0] OFF_COMPARE = 16'hf00c;
  localparam logic [15:0] OFF_STATUS  = 16'hf010;

  logic [31:0] mem [0:(1<<RAM_AW)-1];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  logic              conf_sel;
  logic [15:0]       offset;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_req, rd_req;
  logic [31:0]       wmask;
  logic [31:0]       conf_rdata;
  logic              unused_addr_lsb;

  assign conf_sel        = (data_sram_addr[31:16] == CONF_HI);
  assign offset          = data_sram_addr[15:0];
  assign ram_idx         = data_sram_addr[RAM_AW+1:2];
  assign wr_req          = data_sram_en && (data_sram_wen != 4'b0000);
  assign rd_req          = data_sram_en && (data_sram_wen == 4'b0000);
  assign wmask           = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                            {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
  assign unused_addr_lsb = &{1'b0, data_sram_addr[1:0]};

  // Read mux for the config window; unmapped offsets read as zero
  always_comb begin
    conf_rdata = 32'h0;
    case (offset)
      OFF_LED:     conf_rdata = {16'h0, led_q};
      OFF_SWITCH:  conf_rdata = {24'h0, sw_sync_q};
      OFF_TIMER:   conf_rdata = timer_q;
      OFF_COMPARE: conf_rdata = compare_q;
      OFF_STATUS:  conf_rdata = {31'h0, match_q};
      default:     conf_rdata = 32'h0;
    endcase
  end

  // Next-state for registers: byte-merged writes, free-running timer, sticky match
  always_comb begin
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    compare_d = compare_q;
    match_d   = match_q;
    rdata_d   = rdata_q;

    if (wr_req && conf_sel) begin
      case (offset)
        OFF_LED:     led_d     = (led_q & ~wmask[15:0]) | (data_sram_wdata[15:0] & wmask[15:0]);
        OFF_TIMER:   timer_d   = (timer_q & ~wmask) | (data_sram_wdata & wmask);
        OFF_COMPARE: compare_d = (compare_q & ~wmask) | (data_sram_wdata & wmask);
        OFF_STATUS:  if (data_sram_wen[0] && data_sram_wdata[0]) match_d = 1'b0;
        default:     ;
      endcase
    end

    // Equality uses the current (old) timer and compare, and a set beats a clear
    if (timer_q == compare_q) match_d = 1'b1;

    if (rd_req) rdata_d = conf_sel ? conf_rdata : mem[ram_idx];
  end

  // Register state with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      timer_q   <= 32'h0;
      compare_q <= 32'hffff_ffff;
      match_q   <= 1'b0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_req && !conf_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) mem[ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign timer_irq       = match_q;

endmodule

// File: tb/tb_dsram_responder.sv
// tb/tb_dsram_responder.sv - directed self-checking bench for dsram_responder
module tb_dsram_responder;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        irq;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A_LED  = 32'hbfaf_f000;
  localparam logic [31:0] A_SW   = 32'hbfaf_f004;
  localparam logic [31:0] A_TMR  = 32'hbfaf_f008;
  localparam logic [31:0] A_CMP  = 32'hbfaf_f00c;
  localparam logic [31:0] A_STAT = 32'hbfaf_f010;
  localparam logic [31:0] A_NONE = 32'hbfaf_f020;

  dsram_responder #(.RAM_AW(10), .CONF_HI(16'hbfaf)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .timer_irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One request cycle: drive, pass the rising edge, sample 1ns later, go idle
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    cyc(1'b1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b1, 4'h0, a, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // RAM full-word write, read, hold across idle cycles
    wr(32'h0000_0400, 4'hf, 32'hdead_beef);
    rd(32'h0000_0400);
    chk("ram_rd", rdata, 32'hdead_beef);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("ram_hold", rdata, 32'hdead_beef);
    end

    // Byte-lane merge
    wr(32'h0000_0800, 4'hf, 32'h1122_3344);
    chk("hold_on_wr", rdata, 32'hdead_beef);
    wr(32'h0000_0800, 4'b0101, 32'haabb_ccdd);
    rd(32'h0000_0800);
    chk("ram_merge", rdata, 32'h11bb_33dd);

    // Back-to-back reads
    rd(32'h0000_0400);
    chk("b2b_0", rdata, 32'hdead_beef);
    rd(32'h0000_0800);
    chk("b2b_1", rdata, 32'h11bb_33dd);

    // Read-after-write on consecutive cycles
    wr(32'h0000_0c00, 4'hf, 32'hcafe_f00d);
    rd(32'h0000_0c00);
    chk("raw", rdata, 32'hcafe_f00d);

    // LED, SWITCH, unmapped offset
    wr(A_LED, 4'hf, 32'h1234_abcd);
    chk("led_out", {16'h0, led}, 32'h0000_abcd);
    rd(A_LED);
    chk("led_rd", rdata, 32'h0000_abcd);
    sw = 8'h5a;
    wr(A_SW, 4'hf, 32'hffff_ffff);
    idle();
    rd(A_SW);
    chk("sw_rd", rdata, 32'h0000_005a);
    rd(A_NONE);
    chk("unmapped", rdata, 32'h0);

    // Timer wrap and match
    wr(A_TMR, 4'hf, 32'hffff_fffe);
    chk("irq_a", {31'h0, irq}, 32'h0);
    wr(A_CMP, 4'hf, 32'hffff_ffff);
    chk("irq_b", {31'h0, irq}, 32'h0);
    idle();
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd(A_TMR);
    chk("tmr_wrap", rdata, 32'h0);
    wr(A_STAT, 4'h1, 32'h1);
    chk("irq_clr", {31'h0, irq}, 32'h0);

    // Set beats a simultaneous clear
    wr(A_TMR, 4'hf, 32'h0000_0100);
    wr(A_CMP, 4'hf, 32'h0000_0101);
    idle();
    chk("irq_set2", {31'h0, irq}, 32'h1);
    wr(A_TMR, 4'hf, 32'h0000_0101);
    wr(A_STAT, 4'h1, 32'h1);
    chk("set_wins", {31'h0, irq}, 32'h1);

    // Reset mid-stream with a read pending
    wr(A_LED, 4'h3, 32'h0000_ffff);
    rd(A_LED);
    chk("led_ff", rdata, 32'h0000_ffff);
    en = 1'b1; wen = 4'h0; addr = A_LED;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_led", {16'h0, led}, 32'h0);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_rd_drop", rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    en = 1'b0;
    rd(A_TMR);
    chk("tmr_rst0", rdata, 32'h0);
    rd(A_TMR);
    chk("tmr_rst1", rdata, 32'h1);
    rd(A_CMP);
    chk("cmp_rst", rdata, 32'hffff_ffff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
